// File: rtl/chan_mux_pkg.sv
// Shared definitions for the round-robin channel multiplexer.
package chan_mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_RR     = 1'b1;

    // Next channel index in rotation, wrapping from n-1 back to 0.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        if (idx >= (n - 32'd1)) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotate-priority search: the first requester after ptr, modulo NUM_CH, wins.
module rr_arbiter
    import chan_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_valid
);

    logic [SEL_W-1:0] cand_s;

    // Walk ptr+1 .. ptr+NUM_CH and latch the first channel that requests.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand_s      = ptr;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = SEL_W'(wrap_inc(32'(cand_s), 32'(NUM_CH)));
            if (!grant_valid && req[cand_s]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_s;
            end else begin
                grant_valid = grant_valid;
            end
        end
    end

endmodule

// File: rtl/chan_mux_rr.sv
// N:1 channel multiplexer with one registered output stage, manual or
// round-robin channel selection and valid/ready handshakes on both sides.
module chan_mux_rr
    import chan_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [SEL_W:0]   NUM_CH_W = (SEL_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(NUM_CH - 1);

    logic [SEL_W-1:0]  ptr_r;
    logic [DATA_W-1:0] out_data_r;
    logic [SEL_W-1:0]  out_ch_r;
    logic              out_valid_r;

    logic [SEL_W-1:0]  arb_idx_s;
    logic              arb_valid_s;
    logic [SEL_W-1:0]  grant_idx_s;
    logic              grant_valid_s;
    logic              sel_ok_s;
    logic              load_en_s;
    logic              load_s;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req         (in_valid),
        .ptr         (ptr_r),
        .grant_idx   (arb_idx_s),
        .grant_valid (arb_valid_s)
    );

    // Out-of-range select values never grant (matters when NUM_CH is not a power of two).
    assign sel_ok_s  = ({1'b0, sel} < NUM_CH_W);
    // The output slot can take a beat when it is empty or being drained this cycle.
    assign load_en_s = !out_valid_r || out_ready;
    assign load_s    = load_en_s && grant_valid_s;

    // Pick the grant source according to the current mode.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        if (mode == MODE_RR) begin
            grant_valid_s = arb_valid_s;
            grant_idx_s   = arb_idx_s;
        end else if (sel_ok_s && in_valid[sel]) begin
            grant_valid_s = 1'b1;
            grant_idx_s   = sel;
        end else begin
            grant_valid_s = 1'b0;
            grant_idx_s   = '0;
        end
    end

    // One-hot accept toward the granted channel; held low while reset is asserted.
    always_comb begin
        in_ready = '0;
        if (rst_n && load_s) begin
            in_ready[grant_idx_s] = 1'b1;
        end else begin
            in_ready = '0;
        end
    end

    // Rotation pointer advances to the winner only on a round-robin transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= PTR_INIT;
        end else if (load_s && (mode == MODE_RR)) begin
            ptr_r <= grant_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output stage: load a new beat, retire a drained one, or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_ch_r    <= '0;
            out_valid_r <= 1'b0;
        end else if (load_s) begin
            out_data_r  <= in_data[grant_idx_s*DATA_W +: DATA_W];
            out_ch_r    <= grant_idx_s;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_data  = out_data_r;
    assign out_ch    = out_ch_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_chan_mux_rr.sv
// Directed self-checking bench for chan_mux_rr (4-channel instance plus a
// 3-channel instance for the out-of-range select case).
module tb_chan_mux_rr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        mode = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] in_data = 32'h0;
    logic [3:0]  in_valid = 4'h0;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b0;

    logic        mode3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [23:0] in_data3 = 24'h0;
    logic [2:0]  in_valid3 = 3'h0;
    logic [2:0]  in_ready3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    chan_mux_rr #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    chan_mux_rr #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3),
        .out_ready(out_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid  = 4'hF;
        in_data   = 32'h13121110;
        mode      = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch: got %0d want 0", out_ch); end
        n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
        in_valid  = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_manual();
        mode      = 1'b0;
        sel       = 2'd2;
        in_data   = 32'h13A51110;
        in_valid  = 4'b0100;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL manual_in_ready: got %b want 0100", in_ready); end
        tick();
        in_valid = 4'b0000;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL manual_out_valid: got %b want 1", out_valid); end
        n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL manual_out_data: got %h want a5", out_data); end
        n_vec++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL manual_out_ch: got %0d want 2", out_ch); end
        tick();
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL manual_drain_valid: got %b want 0", out_valid); end
        n_vec++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL manual_data_kept: got %h want a5", out_data); end
    endtask

    task automatic test_rr_all();
        logic [1:0] exp_ch;
        logic [3:0] exp_rdy;
        mode      = 1'b1;
        in_data   = 32'h13121110;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            exp_ch  = 2'(i % 4);
            exp_rdy = 4'b0001 << exp_ch;
            n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rr_all_in_ready[%0d]: got %b want %b", i, in_ready, exp_rdy); end
            tick();
            n_vec++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== (8'h10 + 8'(exp_ch))) begin
                n_err++; $display("FAIL rr_all_beat[%0d]: got v=%b ch=%0d d=%h want v=1 ch=%0d d=%h", i, out_valid, out_ch, out_data, exp_ch, 8'h10 + 8'(exp_ch));
            end
        end
    endtask

    task automatic test_rr_skip_wrap();
        logic [1:0] exp_ch;
        in_valid = 4'b1010;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_ch = (i % 2 == 0) ? 2'd1 : 2'd3;
            tick();
            n_vec++; if (out_ch !== exp_ch || out_valid !== 1'b1) begin
                n_err++; $display("FAIL rr_skip[%0d]: got ch=%0d v=%b want ch=%0d v=1", i, out_ch, out_valid, exp_ch);
            end
        end
        in_valid = 4'b0101;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL rr_after3_in_ready: got %b want 0001", in_ready); end
        tick();
        n_vec++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL rr_after3_first: got %0d want 0", out_ch); end
        tick();
        n_vec++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL rr_after3_second: got %0d want 2", out_ch); end
    endtask

    task automatic test_back_to_back();
        // Held beat is ch2 / 8'h12; pointer sits at 2.
        out_ready = 1'b0;
        in_valid  = 4'hF;
        #1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0000", i, in_ready); end
            n_vec++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h12) begin
                n_err++; $display("FAIL stall_hold[%0d]: got v=%b ch=%0d d=%h want v=1 ch=2 d=12", i, out_valid, out_ch, out_data);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL release_in_ready: got %b want 1000", in_ready); end
        tick();
        in_valid = 4'h0;
        n_vec++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h13) begin
            n_err++; $display("FAIL release_swap: got v=%b ch=%0d d=%h want v=1 ch=3 d=13", out_valid, out_ch, out_data);
        end
        tick();
        n_vec++; if (out_valid !== 1'b0 || out_data !== 8'h13) begin
            n_err++; $display("FAIL release_drain: got v=%b d=%h want v=0 d=13", out_valid, out_data);
        end
    endtask

    task automatic test_sel_boundary();
        mode3      = 1'b0;
        sel3       = 2'd3;
        in_data3   = 24'h222120;
        in_valid3  = 3'b111;
        out_ready3 = 1'b1;
        #1;
        n_vec++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL sel_oob_in_ready: got %b want 000", in_ready3); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL sel_oob_out_valid[%0d]: got %b want 0", i, out_valid3); end
        end
        sel3 = 2'd2;
        #1;
        n_vec++; if (in_ready3 !== 3'b100) begin n_err++; $display("FAIL sel_top_in_ready: got %b want 100", in_ready3); end
        tick();
        n_vec++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 8'h22) begin
            n_err++; $display("FAIL sel_top_beat: got v=%b ch=%0d d=%h want v=1 ch=2 d=22", out_valid3, out_ch3, out_data3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_async_reset();
        // Pointer is at 3 here, so ch1 alone is the next grant.
        mode      = 1'b1;
        out_ready = 1'b0;
        in_valid  = 4'b0010;
        #1;
        n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL areset_load_ready: got %b want 0010", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h11) begin
            n_err++; $display("FAIL areset_held: got v=%b ch=%0d d=%h want v=1 ch=1 d=11", out_valid, out_ch, out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 8'h00) begin
            n_err++; $display("FAIL areset_clear: got v=%b ch=%0d d=%h want v=0 ch=0 d=00", out_valid, out_ch, out_data);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        #1;
        n_vec++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL areset_restart_ready: got %b want 0001", in_ready); end
        tick();
        n_vec++; if (out_valid !== 1'b1 || out_ch !== 2'd0) begin
            n_err++; $display("FAIL areset_restart_ch: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch);
        end
    endtask

    initial begin
        test_reset();
        test_manual();
        test_rr_all();
        test_rr_skip_wrap();
        test_back_to_back();
        test_sel_boundary();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
